reg_write_arbiter: RTL and testbench

//  Shares one enable-gated state register between N requesters (CSR/config

---
 rtl/reg_arb_pkg.sv | 34 +++
 rtl/reg_write_arbiter_pick.sv | 26 ++
 rtl/reg_write_arbiter.sv | 137 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and the round-robin pick function used by the
// register write arbiter.
package reg_arb_pkg;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_t;

  localparam int MAXN  = 32;
  localparam int N_DEF = 4;
  localparam int IDW   = $clog2(N_DEF);

  // Index of the first set bit of req searching ptr, ptr+1, ... mod n,
  // or -1 when req is empty.
  function automatic int rr_pick(
    input logic [MAXN-1:0] req,
    input int              ptr,
    input int              n
  );
    int res;
    int k;
    res = -1;
    for (int j = MAXN - 1; j >= 0; j--) begin
      if (j < n) begin
        k = ptr + j;
        if (k >= n) k = k - n;
        if (req[k]) res = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_pick.sv
// Combinational N-way rotate-priority picker.
// Bit ptr has top priority, priority falls off going upward mod N.
module rr_pick_n
  import reg_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [MAXN-1:0] req_w;
  int              pick;

  always_comb begin
    req_w        = '0;
    req_w[N-1:0] = req;
    pick         = rr_pick(req_w, int'(ptr), N);
    found        = (pick >= 0);
    idx          = found ? IW'(pick) : '0;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// One enable-gated register shared by N writers through a
// round-robin arbiter with bounded lock bursts.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int               N        = 4,
  parameter int               width    = 32,
  parameter logic [width-1:0] init     = '0,
  parameter int               MAX_HOLD = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           lock,
  input  logic [N*width-1:0]     wdata,
  output logic [N-1:0]           gnt,
  output logic [width-1:0]       Q_OUT,
  output logic                   upd,
  output logic [$clog2(N)-1:0]   upd_id,
  output logic                   owned
);

  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

  arb_state_t state, state_nx;
  logic [IW-1:0] ptr, ptr_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [HW-1:0] hold_cnt, hold_nx;

  logic          pk_found;
  logic [IW-1:0] pk_idx;
  logic [IW-1:0] gidx;
  logic          acc;
  logic [width-1:0] d_in;

  function automatic logic [IW-1:0] nxt(
    input logic [IW-1:0] i
  );
    return (i == IW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_pick_n #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pk_found),
    .idx   (pk_idx)
  );

  always_comb begin
    gnt      = '0;
    gidx     = pk_idx;
    acc      = 1'b0;
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    hold_nx  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (pk_found) begin
          gnt[pk_idx] = 1'b1;
          acc         = 1'b1;
          ptr_nx      = nxt(pk_idx);
          if (lock[pk_idx]) begin
            state_nx = OWNED;
            owner_nx = pk_idx;
            hold_nx  = '0;
          end
        end
      end
      OWNED: begin
        gidx = owner;
        if (req[owner]) begin
          gnt[owner] = 1'b1;
          acc        = 1'b1;
        end
        if (hold_cnt != HMAX) hold_nx = hold_cnt + 1'b1;
        // Expiry moves the owner to lowest priority.
        if (hold_cnt == HMAX) begin
          state_nx = IDLE;
          ptr_nx   = nxt(owner);
          hold_nx  = '0;
        end else if (!lock[owner]) begin
          state_nx = IDLE;
          hold_nx  = '0;
        end
      end
      default: ;
    endcase
    if (RST) begin
      gnt = '0;
      acc = 1'b0;
    end
  end

  always_comb begin
    d_in = wdata[width-1:0];
    for (int i = 0; i < N; i++) begin
      if (gidx == IW'(i)) d_in = wdata[i*width +: width];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      owner    <= owner_nx;
      hold_cnt <= hold_nx;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q_OUT  <= init;
      upd    <= 1'b0;
      upd_id <= '0;
    end else begin
      upd <= acc;
      if (acc) begin
        Q_OUT  <= d_in;
        upd_id <= gidx;
      end
    end
  end

  assign owned = (state == OWNED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter against
// a behavioural model of the arbitration rules.
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MH = 8;

  logic           CLK;
  logic           RST;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   Q_OUT;
  logic           upd;
  logic [1:0]     upd_id;
  logic           owned;

  int npass;
  int ntot;

  int       m_ptr;
  bit       m_owned;
  int       m_owner;
  int       m_cnt;
  logic [W-1:0] m_q;
  bit       m_upd;
  int       m_id;

  reg_write_arbiter #(
    .N        (N),
    .width    (W),
    .init     ('0),
    .MAX_HOLD (MH)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .req    (req),
    .lock   (lock),
    .wdata  (wdata),
    .gnt    (gnt),
    .Q_OUT  (Q_OUT),
    .upd    (upd),
    .upd_id (upd_id),
    .owned  (owned)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int m_pick(input logic [N-1:0] r);
    if (m_owned) return r[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_gnt();
    int g;
    logic [N-1:0] v;
    g = m_pick(req);
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_owned = 0;
    m_owner = 0;
    m_cnt   = 0;
    m_q     = '0;
    m_upd   = 0;
    m_id    = 0;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [N*W-1:0] wd);
    req   = r;
    lock  = l;
    wdata = wd;
    #1;
  endtask

  task automatic tick();
    int g;
    g = m_pick(req);
    m_upd = (g >= 0);
    if (g >= 0) begin
      m_id = g;
      m_q  = wdata[g*W +: W];
    end
    if (!m_owned) begin
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (lock[g]) begin
          m_owned = 1;
          m_owner = g;
          m_cnt   = 0;
        end
      end
    end else begin
      m_cnt++;
      if (m_cnt == MH) begin
        m_owned = 0;
        m_ptr   = (m_owner + 1) % N;
      end else if (!lock[m_owner]) begin
        m_owned = 0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    req  = '0;
    lock = '0;
    RST  = 1'b1;
    #2;
    RST  = 1'b0;
    model_reset();
  endtask

  function automatic logic [N*W-1:0] rnd_wd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    RST   = 1'b0;
    req   = '0;
    lock  = '0;
    wdata = '0;
    #1 RST = 1'b1;
    req = 4'b0001;
    #3;
    ntot++;
    if (Q_OUT !== '0) $display("FAIL reset_q got %h want 0", Q_OUT);
    else npass++;
    ntot++;
    if (gnt !== '0) $display("FAIL reset_gnt got %b want 0", gnt);
    else npass++;
    ntot++;
    if (upd !== 1'b0 || owned !== 1'b0)
      $display("FAIL reset_flags got upd=%b owned=%b want 0 0", upd, owned);
    else npass++;
    @(posedge CLK);
    #2 RST = 1'b0;
    req = '0;
    model_reset();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_single_write();
    logic [N*W-1:0] wd;
    apply_reset();
    wd = rnd_wd();
    wd[2*W +: W] = 32'hDEAD_BEEF;
    drive(4'b0100, 4'b0000, wd);
    ntot++;
    if (gnt !== 4'b0100) $display("FAIL single_gnt got %b want 0100", gnt);
    else npass++;
    tick();
    ntot++;
    if (Q_OUT !== 32'hDEADBEEF || upd !== 1'b1 || upd_id !== 2'd2)
      $display("FAIL single_land got q=%h upd=%b id=%0d want deadbeef 1 2",
               Q_OUT, upd, upd_id);
    else npass++;
    drive(4'b0000, 4'b0000, rnd_wd());
    tick();
    ntot++;
    if (upd !== 1'b0 || Q_OUT !== 32'hDEADBEEF)
      $display("FAIL single_hold got q=%h upd=%b want deadbeef 0", Q_OUT, upd);
    else npass++;
  endtask

  task automatic test_fairness();
    logic [N*W-1:0] wd;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      wd = rnd_wd();
      drive(4'b1111, 4'b0000, wd);
      ntot++;
      if (gnt !== (4'b0001 << (c % 4)) || gnt !== m_gnt())
        $display("FAIL fair_gnt c=%0d got %b want %b", c, gnt, 4'b0001 << (c % 4));
      else npass++;
      tick();
      ntot++;
      if (Q_OUT !== wd[(c % 4)*W +: W] || upd_id !== 2'(c % 4))
        $display("FAIL fair_q c=%0d got %h/%0d want %h/%0d", c, Q_OUT, upd_id,
                 wd[(c % 4)*W +: W], c % 4);
      else npass++;
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    drive(4'b0100, 4'b0000, rnd_wd());
    tick();
    drive(4'b1001, 4'b0000, rnd_wd());
    ntot++;
    if (gnt !== 4'b1000) $display("FAIL wrap_first got %b want 1000", gnt);
    else npass++;
    tick();
    drive(4'b1001, 4'b0000, rnd_wd());
    ntot++;
    if (gnt !== 4'b0001) $display("FAIL wrap_second got %b want 0001", gnt);
    else npass++;
    tick();
    drive(4'b0011, 4'b0000, rnd_wd());
    ntot++;
    if (gnt !== 4'b0010) $display("FAIL wrap_ptr1 got %b want 0010", gnt);
    else npass++;
    tick();
  endtask

  task automatic test_lock_burst();
    int oc;
    int w0;
    int guard;
    apply_reset();
    oc    = 0;
    w0    = 0;
    guard = 0;
    do begin
      drive(4'b0011, 4'b0001, rnd_wd());
      ntot++;
      if (gnt !== m_gnt() || gnt !== 4'b0001)
        $display("FAIL burst_gnt cyc=%0d got %b want 0001", guard, gnt);
      else npass++;
      w0++;
      tick();
      ntot++;
      if (owned !== m_owned || Q_OUT !== m_q)
        $display("FAIL burst_state cyc=%0d got owned=%b q=%h want %0d %h",
                 guard, owned, Q_OUT, m_owned, m_q);
      else npass++;
      if (owned) oc++;
      guard++;
    end while (owned && guard < 20);
    ntot++;
    if (oc !== MH || w0 !== MH + 1)
      $display("FAIL burst_len got owned=%0d writes=%0d want %0d %0d",
               oc, w0, MH, MH + 1);
    else npass++;
    drive(4'b0011, 4'b0000, rnd_wd());
    ntot++;
    if (gnt !== 4'b0010) $display("FAIL burst_release got %b want 0010", gnt);
    else npass++;
    tick();
  endtask

  task automatic test_voluntary();
    logic [N*W-1:0] wd;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      wd = rnd_wd();
      drive(4'b1001, (c < 3) ? 4'b0001 : 4'b0000, wd);
      ntot++;
      if (gnt !== 4'b0001) $display("FAIL vol_gnt c=%0d got %b want 0001", c, gnt);
      else npass++;
      tick();
      ntot++;
      if (owned !== (c < 3) || Q_OUT !== wd[W-1:0])
        $display("FAIL vol_state c=%0d got owned=%b q=%h want %0d %h",
                 c, owned, Q_OUT, c < 3, wd[W-1:0]);
      else npass++;
    end
    drive(4'b1000, 4'b0000, rnd_wd());
    ntot++;
    if (gnt !== 4'b1000) $display("FAIL vol_next got %b want 1000", gnt);
    else npass++;
    tick();
  endtask

  task automatic test_owner_idle();
    apply_reset();
    drive(4'b0010, 4'b0010, rnd_wd());
    tick();
    drive(4'b0001, 4'b0010, rnd_wd());
    ntot++;
    if (gnt !== 4'b0000) $display("FAIL idle_owner_gnt got %b want 0000", gnt);
    else npass++;
    tick();
    ntot++;
    if (owned !== 1'b1 || upd !== 1'b0)
      $display("FAIL idle_owner_state got owned=%b upd=%b want 1 0", owned, upd);
    else npass++;
    drive(4'b0001, 4'b0000, rnd_wd());
    tick();
    ntot++;
    if (owned !== 1'b0) $display("FAIL idle_owner_rel got %b want 0", owned);
    else npass++;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    drive(4'b0100, 4'b0100, rnd_wd());
    tick();
    drive(4'b0100, 4'b0100, rnd_wd());
    #1 RST = 1'b1;
    #1;
    ntot++;
    if (Q_OUT !== '0 || gnt !== '0 || upd !== 1'b0 || owned !== 1'b0)
      $display("FAIL midrst got q=%h gnt=%b upd=%b owned=%b want 0 0 0 0",
               Q_OUT, gnt, upd, owned);
    else npass++;
    req  = '0;
    lock = '0;
    #1 RST = 1'b0;
    model_reset();
    drive(4'b1111, 4'b0000, rnd_wd());
    ntot++;
    if (gnt !== 4'b0001) $display("FAIL midrst_ptr got %b want 0001", gnt);
    else npass++;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] l;
    for (int c = 0; c < 400; c++) begin
      r = 4'($urandom);
      l = (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000;
      drive(r, l, rnd_wd());
      ntot++;
      if (gnt !== m_gnt() || (gnt & ~req) !== '0)
        $display("FAIL rnd_gnt c=%0d req=%b got %b want %b", c, r, gnt, m_gnt());
      else npass++;
      tick();
      ntot++;
      if (Q_OUT !== m_q || upd !== m_upd || owned !== m_owned ||
          (m_upd && upd_id !== 2'(m_id)))
        $display("FAIL rnd_out c=%0d got q=%h upd=%b id=%0d own=%b want %h %0d %0d %0d",
                 c, Q_OUT, upd, upd_id, owned, m_q, m_upd, m_id, m_owned);
      else npass++;
    end
  endtask

  initial begin
    npass = 0;
    ntot  = 0;
    model_reset();
    test_reset();
    test_single_write();
    test_fairness();
    test_wrap();
    test_lock_burst();
    test_voluntary();
    test_owner_idle();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
